rv32i_wbarbiter: RTL and testbench

- Shares the single register-file write port between the in-order pipeline writeback and a variable-latency multi-cycle unit (mul/div).
- Multi-cycle results are buffered in a small FIFO and drained into free writeback slots.
- A starvation counter steals a pipeline slot when needed.
- Sits between the writeback stage outputs and the register interface, and drives the writeback-stage forwarding signals.

---
 rtl/rv32i_wbarbiter.sv | 114 +++++++++++
 tb/tb_rv32i_wbarbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rv32i_wbarbiter.sv
// rv32i_wbarbiter: shares the register-file write port between pipeline writeback and a multi-cycle unit
// Ports:
//   clk_i, reset_ni                          clock, synchronous active-low reset
//   pipe_en_i/pipe_reg_i/pipe_data_i         pipeline writeback request
//   mc_valid_i/mc_reg_i/mc_data_i/mc_ready_o multi-cycle result push handshake
//   stall_pipe_o                             pipeline must present a bubble this cycle
//   wb_en_o/wb_reg_o/wb_data_o               registered register-file write port
//   df_wb_enable_o/df_wb_reg_o/df_wb_data_o  forwarding copy of the write port
//   fifo_count_o                             occupied FIFO entries, killed ones included
module rv32i_wbarbiter #(
  parameter int DEPTH = 2,
  parameter int STARVE_MAX = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int SW = $clog2(STARVE_MAX + 1)
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          pipe_en_i,
  input  logic [4:0]    pipe_reg_i,
  input  logic [31:0]   pipe_data_i,
  input  logic          mc_valid_i,
  input  logic [4:0]    mc_reg_i,
  input  logic [31:0]   mc_data_i,
  output logic          mc_ready_o,
  output logic          stall_pipe_o,
  output logic          wb_en_o,
  output logic [4:0]    wb_reg_o,
  output logic [31:0]   wb_data_o,
  output logic          df_wb_enable_o,
  output logic [4:0]    df_wb_reg_o,
  output logic [31:0]   df_wb_data_o,
  output logic [CW-1:0] fifo_count_o
);
  logic [4:0] reg_q [DEPTH];
  logic [31:0] dat_q [DEPTH];
  logic [DEPTH-1:0] kill_q, kill_d;
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic stall_q, stall_d, wb_en_q, wb_en_d;
  logic [4:0] wb_reg_q, wb_reg_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic pipe_req, head_v, head_ok, pop, push, head_wr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  assign mc_ready_o = reset_ni && cnt_q < CW'(DEPTH);
  assign pipe_req = pipe_en_i && pipe_reg_i != 5'd0 && !stall_q;
  assign head_v = cnt_q != '0;
  assign head_ok = head_v && !kill_q[rd_q];
  // a killed head is popped silently; pop only ever happens when the pipeline is idle
  assign pop = head_v && !pipe_req;
  assign head_wr = pop && head_ok;
  // register x0 results are accepted but never need writing
  assign push = mc_valid_i && mc_ready_o && mc_reg_i != 5'd0;

  always_comb begin
    kill_d = kill_q;
    // pipeline writes are always newer, so buffered results to the same register are dead
    for (int i = 0; i < DEPTH; i++)
      if (pipe_req && reg_q[i] == pipe_reg_i) kill_d[i] = 1'b1;
    if (push) kill_d[wr_q] = pipe_req && mc_reg_i == pipe_reg_i;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    wb_en_d = pipe_req || head_wr;
    wb_reg_d = pipe_req ? pipe_reg_i : head_wr ? reg_q[rd_q] : wb_reg_q;
    wb_data_d = pipe_req ? pipe_data_i : head_wr ? dat_q[rd_q] : wb_data_q;
    // the stall cycle blocks pipe_req, so the head is guaranteed its slot then
    stall_d = pipe_req && head_ok && starve_q == SW'(STARVE_MAX - 1);
    starve_d = (pipe_req && head_ok && !stall_d) ? starve_q + SW'(1) : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      kill_q <= '0;
      starve_q <= '0;
      stall_q <= 1'b0;
      wb_en_q <= 1'b0;
      wb_reg_q <= '0;
      wb_data_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      kill_q <= kill_d;
      starve_q <= starve_d;
      stall_q <= stall_d;
      wb_en_q <= wb_en_d;
      wb_reg_q <= wb_reg_d;
      wb_data_q <= wb_data_d;
      if (pop) rd_q <= nxt(rd_q);
      if (push) wr_q <= nxt(wr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      reg_q[wr_q] <= mc_reg_i;
      dat_q[wr_q] <= mc_data_i;
    end
  end

  assign stall_pipe_o = stall_q;
  assign wb_en_o = wb_en_q;
  assign wb_reg_o = wb_reg_q;
  assign wb_data_o = wb_data_q;
  assign df_wb_enable_o = wb_en_q;
  assign df_wb_reg_o = wb_reg_q;
  assign df_wb_data_o = wb_data_q;
  assign fifo_count_o = cnt_q;
endmodule

// File: tb/tb_rv32i_wbarbiter.sv
// tb_rv32i_wbarbiter: scoreboard bench comparing rv32i_wbarbiter against a queue-based reference model
module tb_rv32i_wbarbiter;
  localparam int DEPTH = 2;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst_n, pipe_en, mc_valid, mc_ready, stall, wb_en, df_en;
  logic [4:0] pipe_reg, mc_reg, wb_reg, df_reg;
  logic [31:0] pipe_data, mc_data, wb_data, df_data;
  logic [1:0] fifo_count;

  rv32i_wbarbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk), .reset_ni(rst_n),
    .pipe_en_i(pipe_en), .pipe_reg_i(pipe_reg), .pipe_data_i(pipe_data),
    .mc_valid_i(mc_valid), .mc_reg_i(mc_reg), .mc_data_i(mc_data), .mc_ready_o(mc_ready),
    .stall_pipe_o(stall), .wb_en_o(wb_en), .wb_reg_o(wb_reg), .wb_data_o(wb_data),
    .df_wb_enable_o(df_en), .df_wb_reg_o(df_reg), .df_wb_data_o(df_data),
    .fifo_count_o(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {logic [4:0] r; logic [31:0] d; bit k;} ent_t;
  typedef struct {bit en; logic [4:0] r; logic [31:0] d; bit stall; int cnt; bit rdy;} exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  int m_starve;
  bit m_stall, m_en, acc_last;
  logic [4:0] m_reg;
  logic [31:0] m_data;
  int n_cmp = 0, n_bad = 0;

  // one cycle of the reference behaviour, evaluated on the inputs about to be clocked in
  task automatic model();
    bit preq, acc, live;
    acc_last = 1'b0;
    if (!rst_n) begin
      mq.delete();
      m_starve = 0;
      m_stall = 1'b0;
      m_en = 1'b0;
      m_reg = '0;
      m_data = '0;
    end else begin
      preq = pipe_en && pipe_reg != 0 && !m_stall;
      acc = mc_valid && mq.size() < DEPTH;
      live = mq.size() > 0 && !mq[0].k;
      m_en = 1'b0;
      if (preq) begin
        m_en = 1'b1;
        m_reg = pipe_reg;
        m_data = pipe_data;
        foreach (mq[i]) if (mq[i].r == pipe_reg) mq[i].k = 1'b1;
      end else if (mq.size() > 0) begin
        if (!mq[0].k) begin
          m_en = 1'b1;
          m_reg = mq[0].r;
          m_data = mq[0].d;
        end
        void'(mq.pop_front());
      end
      if (live && preq && m_starve == STARVE_MAX - 1) begin
        m_stall = 1'b1;
        m_starve = 0;
      end else begin
        m_stall = 1'b0;
        m_starve = (live && preq) ? m_starve + 1 : 0;
      end
      if (acc && mc_reg != 0) mq.push_back('{mc_reg, mc_data, preq && mc_reg == pipe_reg});
      acc_last = acc;
    end
    exp_q.push_back('{m_en, m_reg, m_data, m_stall, mq.size(), rst_n && mq.size() < DEPTH});
  endtask

  task automatic step();
    model();
    @(posedge clk);
    @(negedge clk);
    if (acc_last) mc_valid = 1'b0;
  endtask

  task automatic push_mc(input logic [4:0] r, input logic [31:0] d);
    mc_valid = 1'b1;
    mc_reg = r;
    mc_data = d;
  endtask

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wb_en", {31'd0, wb_en}, {31'd0, e.en});
        chk("wb_reg", {27'd0, wb_reg}, {27'd0, e.r});
        chk("wb_data", wb_data, e.d);
        chk("df_en", {31'd0, df_en}, {31'd0, e.en});
        chk("df_reg", {27'd0, df_reg}, {27'd0, e.r});
        chk("df_data", df_data, e.d);
        chk("stall_pipe", {31'd0, stall}, {31'd0, e.stall});
        chk("fifo_count", {30'd0, fifo_count}, e.cnt);
        chk("mc_ready", {31'd0, mc_ready}, {31'd0, e.rdy});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    pipe_en = 1'b0;
    pipe_reg = '0;
    pipe_data = '0;
    push_mc(5'd1, 32'h1234);
    repeat (2) step();
    rst_n = 1'b1;
    mc_valid = 1'b0;
    step();
    pipe_en = 1'b1;
    pipe_reg = 5'd5;
    pipe_data = 32'hDEADBEEF;
    step();
    pipe_reg = 5'd0;
    step();
    pipe_en = 1'b0;
    push_mc(5'd7, 32'h11);
    repeat (3) step();
    pipe_en = 1'b1;
    pipe_reg = 5'd1;
    for (int i = 0; i < 3; i++) begin
      push_mc(5'(10 + i), 32'hA0 + i);
      for (int c = 0; c < 20 && mc_valid; c++) begin
        pipe_data = $urandom;
        step();
      end
    end
    pipe_en = 1'b0;
    repeat (4) step();
    pipe_en = 1'b1;
    pipe_reg = 5'd2;
    push_mc(5'd9, 32'h99);
    step();
    pipe_reg = 5'd9;
    pipe_data = 32'h9999;
    step();
    pipe_en = 1'b0;
    repeat (3) step();
    pipe_en = 1'b1;
    pipe_reg = 5'd3;
    push_mc(5'd4, 32'h44);
    for (int c = 0; c < 9; c++) begin
      pipe_data = $urandom;
      step();
    end
    pipe_en = 1'b0;
    push_mc(5'd6, 32'h66);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (2) step();
    for (int c = 0; c < 600; c++) begin
      rst_n = $urandom_range(0, 63) != 0;
      pipe_en = $urandom_range(0, 9) < 7;
      pipe_reg = 5'($urandom_range(0, 7));
      pipe_data = $urandom;
      if (!mc_valid && $urandom_range(0, 1) == 1) push_mc(5'($urandom_range(0, 7)), $urandom);
      step();
    end
    rst_n = 1'b1;
    pipe_en = 1'b0;
    mc_valid = 1'b0;
    repeat (4) step();
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
